// File: rtl/mlp_sequencer.sv
// ---------------------------------------------------------------------------
// mlp_sequencer
//
// Top-level inference controller for the MLP datapath. It takes one input
// vector per transaction and holds it on the hidden-layer input bus. It then
// starts the hidden layer and waits for its done flag to rise, starts the
// output layer and waits for its done flag to rise, and finally offers the
// result to the consumer. A wait that runs too long parks the controller in a
// sticky error state until err_clr is asserted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input vector handshake (in_ready high only in IDLE)
//   in_data               packed input vector, element j at [(j+1)*DATA_W-1 -: DATA_W]
//   hid_bus               registered copy of the last accepted vector
//   hid_start, hid_done   hidden layer start strobe / all-done level
//   out_start, out_done   output layer start strobe / all-done level
//   res_valid / res_ready result handshake toward the consumer
//   busy                  high in every state except IDLE
//   err, err_clr          sticky timeout error and its clear
//   inf_count             number of completed (handshaken) inferences, wrapping
// ---------------------------------------------------------------------------
module mlp_sequencer #(
   parameter int IN_DIM         = 4,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W*IN_DIM-1:0] in_data,
   output logic [DATA_W*IN_DIM-1:0] hid_bus,
   output logic                     hid_start,
   input  logic                     hid_done,
   output logic                     out_start,
   input  logic                     out_done,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic                     busy,
   output logic                     err,
   input  logic                     err_clr,
   output logic [CNT_W-1:0]         inf_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      HID_START,
      HID_WAIT,
      OUT_START,
      OUT_WAIT,
      RESULT,
      ERROR
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [TW-1:0] tcnt;
   logic          hid_done_q;
   logic          out_done_q;
   logic          hid_edge;
   logic          out_edge;
   logic          timeout;
   logic          in_wait;
   logic          wait_entry;

   // Completion is the rising edge only, so a done level still high from the
   // previous run cannot be mistaken for completion of the current one.
   assign hid_edge = hid_done & ~hid_done_q;
   assign out_edge = out_done & ~out_done_q;
   assign timeout  = (tcnt == TW'(TIMEOUT_CYCLES - 1));
   assign in_wait  = (state == HID_WAIT) || (state == OUT_WAIT);
   assign wait_entry = (state_next != state) &&
                       ((state_next == HID_WAIT) || (state_next == OUT_WAIT));

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_next = HID_START;
         end
         HID_START: state_next = HID_WAIT;
         HID_WAIT: begin
            // A done edge in the same cycle as the timeout wins.
            if (hid_edge)     state_next = OUT_START;
            else if (timeout) state_next = ERROR;
         end
         OUT_START: state_next = OUT_WAIT;
         OUT_WAIT: begin
            if (out_edge)     state_next = RESULT;
            else if (timeout) state_next = ERROR;
         end
         RESULT: if (res_ready) state_next = IDLE;
         ERROR:  if (err_clr)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes and status flags are registered from the next state, so each one
   // is high exactly while the FSM sits in the matching state and the start
   // strobes always return low between runs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hid_bus    <= '0;
         hid_start  <= 1'b0;
         out_start  <= 1'b0;
         res_valid  <= 1'b0;
         err        <= 1'b0;
         inf_count  <= '0;
         tcnt       <= '0;
         hid_done_q <= 1'b0;
         out_done_q <= 1'b0;
      end else begin
         state      <= state_next;
         hid_start  <= (state_next == HID_START);
         out_start  <= (state_next == OUT_START);
         res_valid  <= (state_next == RESULT);
         err        <= (state_next == ERROR);
         hid_done_q <= hid_done;
         out_done_q <= out_done;

         if (state == IDLE && in_valid)
            hid_bus <= in_data;

         if (state == RESULT && res_ready)
            inf_count <= inf_count + CNT_W'(1);

         if (wait_entry)
            tcnt <= '0;
         else if (in_wait)
            tcnt <= tcnt + TW'(1);
      end
   end

endmodule

// File: tb/tb_mlp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mlp_sequencer
//
// Directed testbench for mlp_sequencer with a 16-cycle timeout. Inputs are
// driven 1 time unit after each rising clock edge and outputs are sampled at
// the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_mlp_sequencer;

   localparam int IN_DIM = 4;
   localparam int DATA_W = 8;
   localparam int TMO    = 16;
   localparam int CNT_W  = 16;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_W*IN_DIM-1:0] in_data;
   logic [DATA_W*IN_DIM-1:0] hid_bus;
   logic                     hid_start;
   logic                     hid_done;
   logic                     out_start;
   logic                     out_done;
   logic                     res_valid;
   logic                     res_ready;
   logic                     busy;
   logic                     err;
   logic                     err_clr;
   logic [CNT_W-1:0]         inf_count;

   int n_checks = 0;
   int n_pass   = 0;

   mlp_sequencer #(
      .IN_DIM(IN_DIM),
      .DATA_W(DATA_W),
      .TIMEOUT_CYCLES(TMO),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .hid_bus(hid_bus),
      .hid_start(hid_start),
      .hid_done(hid_done),
      .out_start(out_start),
      .out_done(out_done),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .busy(busy),
      .err(err),
      .err_clr(err_clr),
      .inf_count(inf_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one inference from IDLE up to the first RESULT cycle.
   // hl: cycles from hid_start to hid_done rising; ol: same for out_start/out_done.
   task automatic inference(input logic [31:0] d, input int hl, input int ol,
                            input bit keep_valid, input string tag);
      in_data  = d;
      in_valid = 1'b1;
      step();
      check({tag, "_hid_start"}, hid_start, 1'b1);
      check({tag, "_hid_bus"}, hid_bus, d);
      check({tag, "_in_ready_busy"}, {in_ready, busy}, 2'b01);
      if (!keep_valid) in_valid = 1'b0;
      for (int i = 0; i < hl; i++) begin
         step();
         check({tag, "_hid_wait_strobes"}, {hid_start, out_start}, 2'b00);
      end
      hid_done = 1'b1;
      step();
      check({tag, "_out_start"}, out_start, 1'b1);
      hid_done = 1'b0;
      for (int i = 0; i < ol; i++) begin
         step();
         check({tag, "_out_wait"}, {out_start, res_valid}, 2'b00);
      end
      out_done = 1'b1;
      step();
      check({tag, "_res_valid"}, res_valid, 1'b1);
      out_done = 1'b0;
   endtask

   logic [31:0] vecs [3];

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      hid_done  = 1'b0;
      out_done  = 1'b0;
      res_ready = 1'b0;
      err_clr   = 1'b0;
      vecs[0]   = 32'h11223344;
      vecs[1]   = 32'h55667788;
      vecs[2]   = 32'h99aabbcc;

      // Reset state
      step();
      step();
      check("rst_hid_bus", hid_bus, 32'h0);
      check("rst_flags", {hid_start, out_start, res_valid, err, busy}, 5'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_inf_count", inf_count, 16'd0);
      rst_n = 1'b1;
      step();

      // Single inference
      res_ready = 1'b1;
      inference(32'h04030201, 5, 3, 1'b0, "single");
      step();
      check("single_res_drop", res_valid, 1'b0);
      check("single_count", inf_count, 16'd1);
      check("single_in_ready", in_ready, 1'b1);
      check("single_hid_bus_hold", hid_bus, 32'h04030201);

      // Stale done: hid_done held high across the start of a new run
      hid_done = 1'b1;
      step();
      in_data  = 32'h08070605;
      in_valid = 1'b1;
      step();
      check("stale_hid_start", hid_start, 1'b1);
      in_valid = 1'b0;
      step();
      check("stale_no_out_start", out_start, 1'b0);
      hid_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("stale_wait", out_start, 1'b0);
      end
      hid_done = 1'b1;
      step();
      check("stale_out_start", out_start, 1'b1);
      hid_done = 1'b0;
      step();
      out_done = 1'b1;
      step();
      check("stale_res_valid", res_valid, 1'b1);
      out_done = 1'b0;
      step();
      check("stale_count", inf_count, 16'd2);

      // Backpressure
      res_ready = 1'b0;
      inference(32'h0c0b0a09, 2, 2, 1'b0, "bp");
      for (int i = 0; i < 10; i++) begin
         step();
         check("bp_hold", {res_valid, in_ready, inf_count}, {1'b1, 1'b0, 16'd2});
      end
      res_ready = 1'b1;
      step();
      check("bp_release", {res_valid, in_ready, inf_count}, {1'b0, 1'b1, 16'd3});
      step();
      check("bp_count_once", inf_count, 16'd3);

      // Timeout in HID_WAIT
      err_clr  = 1'b1;               // ignored outside ERROR
      in_data  = 32'hdeadbeef;
      in_valid = 1'b1;
      step();
      check("tmo_hid_start", {hid_start, err}, 2'b10);
      in_valid = 1'b0;
      err_clr  = 1'b0;
      step();                        // first HID_WAIT cycle
      for (int i = 0; i < TMO - 1; i++) begin
         step();
         check("tmo_waiting", {err, out_start}, 2'b00);
      end
      step();
      check("tmo_err", {err, busy, in_ready}, 3'b110);
      step();
      check("tmo_sticky", {err, out_start, hid_start}, 3'b100);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("tmo_clear", {err, in_ready, busy}, 3'b010);

      // Reset during OUT_WAIT
      in_data  = 32'h0f0e0d0c;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      hid_done = 1'b1;
      step();
      check("rstmid_out_start", out_start, 1'b1);
      hid_done = 1'b0;
      step();                        // OUT_WAIT
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_async", {hid_bus, inf_count, busy, err, res_valid, out_start, in_ready},
            {32'h0, 16'd0, 5'b00001});
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("rstmid_quiet", {out_start, res_valid, busy}, 3'b000);
      end

      // Back-to-back with in_valid held high
      res_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         inference(vecs[k], 2, 1, 1'b1, "b2b");
         step();
         check("b2b_idle_gap", {hid_start, in_ready}, 2'b01);
      end
      in_valid = 1'b0;
      step();
      check("b2b_count", inf_count, 16'd3);
      check("b2b_last_bus", hid_bus, 32'h99aabbcc);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mlp_sequencer.md
Name: mlp_sequencer

Overview:
- Top-level inference controller for the MLP datapath.
- Accepts one input vector per transaction over a valid/ready handshake and holds it stable on the hidden-layer input bus.
- Issues single-cycle start strobes to the hidden layer, then to the output layer, waiting on each layer's all-done flag.
- Presents completion to the consumer with a valid/ready handshake, with timeout detection and a sticky error state.

Parameters:
IN_DIM, 4, number of input elements per vector
DATA_W, 8, width of one input element
TIMEOUT_CYCLES, 1024, max cycles allowed per layer in a wait state before error (>=4)
CNT_W, 16, width of the completed-inference counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input vector valid
in_ready  output  1  sequencer can accept a vector
in_data  input  DATA_W*IN_DIM  packed input vector, element j at bits [(j+1)*DATA_W-1 -: DATA_W]
hid_bus  output  DATA_W*IN_DIM  registered copy of accepted vector, drives the hidden layer input bus
hid_start  output  1  start strobe to hidden layer
hid_done  input  1  hidden layer all-done flag (level)
out_start  output  1  start strobe to output layer
out_done  input  1  output layer all-done flag (level)
res_valid  output  1  result available on output layer outputs
res_ready  input  1  consumer accepts result
busy  output  1  high in any state other than IDLE
err  output  1  sticky timeout error
err_clr  input  1  clears error, returns to IDLE
inf_count  output  CNT_W  number of completed (handshaken) inferences

Behaviour:
- Reset (async, rst_n low): state=IDLE, hid_bus=0, hid_start=0, out_start=0, res_valid=0, err=0, inf_count=0, timeout counter=0, done-edge registers=0. Reset mid-operation aborts immediately; no pending strobe is emitted after release.
- States: IDLE, HID_START, HID_WAIT, OUT_START, OUT_WAIT, RESULT, ERROR.
- in_ready=1 only in IDLE, driven combinationally from state.
- IDLE: on in_valid&in_ready, capture in_data into hid_bus and go to HID_START. hid_bus holds its value until the next accept.
- HID_START: hid_start=1 for exactly this cycle, then HID_WAIT. The strobe is registered, so it is always low for at least 1 cycle between runs, which the downstream rising-edge detector requires.
- HID_WAIT: completion is the rising edge of hid_done (hid_done=1 and its registered previous value=0). A done level left high from the prior run is ignored. On the edge go to OUT_START.
- OUT_START: out_start=1 for one cycle, then OUT_WAIT.
- OUT_WAIT: on the rising edge of out_done go to RESULT.
- Timeout: the counter clears on entry to HID_WAIT and to OUT_WAIT and increments each cycle in a wait state. If it reaches TIMEOUT_CYCLES-1 without a done edge, the next state is ERROR. A done edge in the same cycle takes priority over the timeout.
- RESULT: res_valid=1 until res_valid&res_ready. In that cycle, inf_count increments (wrapping modulo 2^CNT_W) and the state returns to IDLE. res_valid is registered and deasserts the cycle after the handshake.
- Back-to-back: a new vector can be accepted in the cycle after the return to IDLE; no combinational ready-through from res_ready.
- ERROR: err=1, busy=1, all strobes 0. Stays until err_clr=1, then IDLE on the next cycle with err=0. err_clr outside ERROR is ignored.
- Minimum latency from accept to res_valid: 1 (HID_START) + 1 (HID_WAIT to edge) + hidden latency + 1 (OUT_START) + output latency + 1 cycles.

Test Plan:
- Single inference: in_data=32'h04_03_02_01, hid_done rises 5 cycles after hid_start, out_done rises 3 cycles after out_start, res_ready=1 -> hid_bus=32'h04030201, one-cycle hid_start and out_start, res_valid for 1 cycle, inf_count=1, in_ready back to 1.
- Stale done: hold hid_done=1 continuously from a prior run, start a new run, drop hid_done 1 cycle after hid_start and raise it 4 cycles later -> out_start only after the new rising edge, never earlier.
- Backpressure: res_ready=0 for 10 cycles -> res_valid held high, in_ready=0, inf_count unchanged; res_ready=1 -> count increments once.
- Timeout: TIMEOUT_CYCLES=16, hid_done never rises -> err=1 exactly 16 cycles after HID_WAIT entry, out_start never asserted; err_clr pulse -> IDLE, err=0, in_ready=1.
- Reset mid-run: assert rst_n=0 during OUT_WAIT -> all outputs take reset values asynchronously, no out_start/res_valid after release, inf_count=0.
- Back-to-back 3 vectors with in_valid held high -> 3 distinct hid_bus captures, each hid_start separated by low cycles, inf_count=3.
